// File: rtl/rx_reset_sm_mc_if.sv
// Per-quad status/reset bundle between the PCS hard block, the RX reset sequencer and the MAC core.
// The master side supplies lock/signal status and requests; the slave side is the sequencer.
interface rx_reset_sm_mc_if #(
    parameter int NUM_CH = 4
);
    logic              tx_pll_lol_qd_s;
    logic [NUM_CH-1:0] rx_cdr_lol_ch_s;
    logic [NUM_CH-1:0] rx_los_low_ch_s;
    logic [NUM_CH-1:0] power_down;
    logic [NUM_CH-1:0] fault_clr;
    logic [NUM_CH-1:0] rx_serdes_rst_ch_c;
    logic [NUM_CH-1:0] rx_pcs_rst_ch_c;
    logic [NUM_CH-1:0] rx_ready;
    logic [NUM_CH-1:0] rx_fault;

    modport master (
        output tx_pll_lol_qd_s, rx_cdr_lol_ch_s, rx_los_low_ch_s, power_down, fault_clr,
        input  rx_serdes_rst_ch_c, rx_pcs_rst_ch_c, rx_ready, rx_fault
    );

    modport slave (
        input  tx_pll_lol_qd_s, rx_cdr_lol_ch_s, rx_los_low_ch_s, power_down, fault_clr,
        output rx_serdes_rst_ch_c, rx_pcs_rst_ch_c, rx_ready, rx_fault
    );
endinterface

// File: rtl/rx_reset_sm_mc.sv
// Multi-channel RX reset sequencer for the ECP3 SERDES quad: one independent reset FSM per channel,
// sharing the quad TX PLL lock, with per-channel ready/fault status and a bounded-retry fault state.
module rx_reset_sm_mc #(
    parameter int NUM_CH    = 4,
    parameter int T1_CYCLES = 2,
    parameter int T2_CYCLES = 200000,
    parameter int MAX_RETRY = 8
) (
    input  logic            refclkdiv2,
    input  logic            rst,
    rx_reset_sm_mc_if.slave bus
);

`ifdef SIM
    localparam int T2_EFF = 32;
`else
    localparam int T2_EFF = T2_CYCLES;
`endif

    localparam int            TW        = $clog2(T2_EFF);
    localparam logic [TW-1:0] T1_LAST   = TW'(T1_CYCLES - 1);
    localparam logic [TW-1:0] T2_LAST   = TW'(T2_EFF - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
    localparam bit            RETRY_EN  = (MAX_RETRY != 0);

    typedef enum logic [2:0] {
        WAIT_FOR_PLOL   = 3'd0,
        RX_SERDES_RESET = 3'd1,
        WAIT_FOR_TIMER1 = 3'd2,
        CHECK_LOL_LOS   = 3'd3,
        WAIT_FOR_TIMER2 = 3'd4,
        NORMAL          = 3'd5,
        FAULT           = 3'd6
    } state_t;

    logic [NUM_CH-1:0] ll_d, ll_q, los_q, pd_q, clr_q;
    logic              pll_q;
    logic [NUM_CH-1:0] serdes_rst_vec, pcs_rst_vec, ready_vec, fault_vec;

    // Status pipeline; flops default to "not locked" so nothing starts before real status arrives.
    // NOTE: sequential state uses <= so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge refclkdiv2 or posedge rst) begin
        if (rst) begin
            ll_d  <= '1;
            ll_q  <= '1;
            los_q <= '1;
            pd_q  <= '0;
            clr_q <= '1;
            pll_q <= 1'b1;
        end else begin
            ll_d  <= bus.rx_cdr_lol_ch_s | bus.rx_los_low_ch_s;
            ll_q  <= ll_d;
            los_q <= bus.rx_los_low_ch_s;
            pd_q  <= bus.power_down;
            clr_q <= bus.fault_clr;
            pll_q <= bus.tx_pll_lol_qd_s;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t        state, state_nxt;
        logic [TW-1:0] timer, timer_nxt;
        logic [3:0]    retry, retry_nxt;
        logic [3:0]    retry_inc;
        logic          ll_edge;
        logic          serdes_r, pcs_r, ready_r, fault_r;

        assign ll_edge   = ll_d[c] ^ ll_q[c];
        assign retry_inc = (retry == 4'hF) ? retry : retry + 4'd1;

        always_ff @(posedge refclkdiv2 or posedge rst) begin
            if (rst) begin
                state <= WAIT_FOR_PLOL;
                timer <= '0;
                retry <= '0;
            end else begin
                state <= state_nxt;
                timer <= timer_nxt;
                retry <= retry_nxt;
            end
        end

        // One timer serves both wait states; it stops at its terminal value so it can never wrap.
        always_comb begin
            // NOTE: every signal written here gets a default first, so no path can infer a latch.
            state_nxt = state;
            timer_nxt = timer;
            retry_nxt = retry;
            if (pd_q[c]) begin
                state_nxt = WAIT_FOR_PLOL;
                if (state == FAULT) retry_nxt = '0;
            end else begin
                case (state)
                    WAIT_FOR_PLOL:
                        if (!pll_q && !los_q[c]) state_nxt = RX_SERDES_RESET;
                    RX_SERDES_RESET: begin
                        timer_nxt = '0;
                        state_nxt = WAIT_FOR_TIMER1;
                    end
                    WAIT_FOR_TIMER1:
                        if (timer == T1_LAST) state_nxt = CHECK_LOL_LOS;
                        else                  timer_nxt = timer + TW'(1);
                    CHECK_LOL_LOS: begin
                        timer_nxt = '0;
                        state_nxt = WAIT_FOR_TIMER2;
                    end
                    WAIT_FOR_TIMER2: begin
                        if (ll_edge) begin
                            state_nxt = CHECK_LOL_LOS;
                        end else if (timer != T2_LAST) begin
                            timer_nxt = timer + TW'(1);
                        end else if (!ll_q[c]) begin
                            state_nxt = NORMAL;
                            retry_nxt = '0;
                        end else begin
                            retry_nxt = retry_inc;
                            state_nxt = (RETRY_EN && retry_inc >= RETRY_MAX) ? FAULT : WAIT_FOR_PLOL;
                        end
                    end
                    NORMAL:
                        if (ll_q[c]) state_nxt = WAIT_FOR_PLOL;
                    FAULT:
                        if (clr_q[c]) begin
                            state_nxt = WAIT_FOR_PLOL;
                            retry_nxt = '0;
                        end
                    default:
                        state_nxt = WAIT_FOR_PLOL;
                endcase
            end
        end

        // Registered state decode: outputs trail the state register by one cycle, glitch-free.
        always_ff @(posedge refclkdiv2 or posedge rst) begin
            if (rst) begin
                serdes_r <= 1'b0;
                pcs_r    <= 1'b1;
                ready_r  <= 1'b0;
                fault_r  <= 1'b0;
            end else begin
                serdes_r <= (state == RX_SERDES_RESET) || (state == WAIT_FOR_TIMER1);
                pcs_r    <= (state != NORMAL);
                ready_r  <= (state == NORMAL);
                fault_r  <= (state == FAULT);
            end
        end

        assign serdes_rst_vec[c] = serdes_r;
        assign pcs_rst_vec[c]    = pcs_r;
        assign ready_vec[c]      = ready_r;
        assign fault_vec[c]      = fault_r;
    end

    assign bus.rx_serdes_rst_ch_c = serdes_rst_vec;
    assign bus.rx_pcs_rst_ch_c    = pcs_rst_vec;
    assign bus.rx_ready           = ready_vec;
    assign bus.rx_fault           = fault_vec;

endmodule

// File: tb/tb_rx_reset_sm_mc.sv
// Directed-plus-random bench for rx_reset_sm_mc; a phase/countdown reference model predicts
// every output each cycle, and directed steps check the headline timing of each scenario.
module tb_rx_reset_sm_mc;
    localparam int NUM_CH     = 4;
    localparam int T1_CYCLES  = 2;
    localparam int T2_CYCLES  = 32;
    localparam int MAX_RETRY  = 3;
    localparam int READY_TICK = T1_CYCLES + T2_CYCLES + 5;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rx_reset_sm_mc_if #(.NUM_CH(NUM_CH)) bus ();

    rx_reset_sm_mc #(
        .NUM_CH(NUM_CH), .T1_CYCLES(T1_CYCLES), .T2_CYCLES(T2_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .refclkdiv2(clk),
        .rst       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what each channel is doing, and how many cycles remain in a timed phase.
    typedef enum int {P_IDLE, P_PULSE, P_HOLD, P_CHECK, P_SETTLE, P_UP, P_FAULT} phase_t;
    typedef struct packed {
        logic              pll;
        logic [NUM_CH-1:0] ll;
        logic [NUM_CH-1:0] los;
        logic [NUM_CH-1:0] pd;
        logic [NUM_CH-1:0] clr;
    } obs_t;

    obs_t              hist[$];
    phase_t            ph   [NUM_CH];
    int                left [NUM_CH];
    int                tries[NUM_CH];
    logic [NUM_CH-1:0] exp_serdes, exp_pcs, exp_ready, exp_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        obs_t r;
        r.pll = 1'b1; r.ll = '1; r.los = '1; r.pd = '0; r.clr = '1;
        hist.delete();
        hist.push_back(r);
        hist.push_back(r);
        for (int c = 0; c < NUM_CH; c++) begin
            ph[c] = P_IDLE; left[c] = 0; tries[c] = 0;
        end
        exp_serdes = '0; exp_pcs = '1; exp_ready = '0; exp_fault = '0;
    endtask

    // The FSM acts on status one cycle old; the lock decision uses the combined lol/los two cycles old.
    task automatic model_clock();
        obs_t cur, s1, s2;
        cur.pll = bus.tx_pll_lol_qd_s;
        cur.ll  = bus.rx_cdr_lol_ch_s | bus.rx_los_low_ch_s;
        cur.los = bus.rx_los_low_ch_s;
        cur.pd  = bus.power_down;
        cur.clr = bus.fault_clr;
        hist.push_back(cur);
        while (hist.size() > 3) void'(hist.pop_front());
        s1 = hist[1];
        s2 = hist[0];
        for (int c = 0; c < NUM_CH; c++) begin
            exp_serdes[c] = (ph[c] == P_PULSE) || (ph[c] == P_HOLD);
            exp_pcs[c]    = (ph[c] != P_UP);
            exp_ready[c]  = (ph[c] == P_UP);
            exp_fault[c]  = (ph[c] == P_FAULT);
            if (s1.pd[c]) begin
                if (ph[c] == P_FAULT) tries[c] = 0;
                ph[c] = P_IDLE;
            end else begin
                case (ph[c])
                    P_IDLE:  if (!s1.pll && !s1.los[c]) ph[c] = P_PULSE;
                    P_PULSE: begin ph[c] = P_HOLD; left[c] = T1_CYCLES; end
                    P_HOLD: begin
                        left[c]--;
                        if (left[c] == 0) ph[c] = P_CHECK;
                    end
                    P_CHECK: begin ph[c] = P_SETTLE; left[c] = T2_CYCLES; end
                    P_SETTLE: begin
                        if (s1.ll[c] != s2.ll[c]) begin
                            ph[c] = P_CHECK;
                        end else begin
                            left[c]--;
                            if (left[c] == 0) begin
                                if (!s2.ll[c]) begin
                                    ph[c] = P_UP; tries[c] = 0;
                                end else begin
                                    if (tries[c] < 15) tries[c]++;
                                    ph[c] = (MAX_RETRY != 0 && tries[c] >= MAX_RETRY) ? P_FAULT : P_IDLE;
                                end
                            end
                        end
                    end
                    P_UP:    if (s2.ll[c]) ph[c] = P_IDLE;
                    default: if (s1.clr[c]) begin ph[c] = P_IDLE; tries[c] = 0; end
                endcase
            end
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        @(negedge clk);
        check("serdes", 32'(bus.rx_serdes_rst_ch_c), 32'(exp_serdes));
        check("pcs",    32'(bus.rx_pcs_rst_ch_c),    32'(exp_pcs));
        check("ready",  32'(bus.rx_ready),           32'(exp_ready));
        check("fault",  32'(bus.rx_fault),           32'(exp_fault));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_serdes", 32'(bus.rx_serdes_rst_ch_c), 32'(0));
        check("rst_pcs",    32'(bus.rx_pcs_rst_ch_c),    32'({NUM_CH{1'b1}}));
        check("rst_ready",  32'(bus.rx_ready),           32'(0));
        check("rst_fault",  32'(bus.rx_fault),           32'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready(input logic [NUM_CH-1:0] mask, input int budget, input string tag);
        int n;
        n = 0;
        while ((bus.rx_ready & mask) != mask && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.rx_ready & mask), 32'(mask));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ready_at  [NUM_CH];
        int   serdes_cnt[NUM_CH];
        int   per;
        int   n;
        int   lat;
        int   rises;
        logic seen;
        logic prev;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.tx_pll_lol_qd_s = 1'b0;
        bus.rx_cdr_lol_ch_s = '0;
        bus.rx_los_low_ch_s = '0;
        bus.power_down      = '0;
        bus.fault_clr       = '0;
        #2;
        apply_reset();

        // Clean bring-up on every channel.
        for (int c = 0; c < NUM_CH; c++) begin
            ready_at[c] = 0; serdes_cnt[c] = 0;
        end
        for (int i = 1; i <= READY_TICK + 5; i++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.rx_serdes_rst_ch_c[c]) serdes_cnt[c]++;
                if (bus.rx_ready[c] && ready_at[c] == 0) ready_at[c] = i;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("t1_ready_at_ch%0d", c), ready_at[c], READY_TICK);
            check($sformatf("t1_serdes_len_ch%0d", c), serdes_cnt[c], T1_CYCLES + 1);
        end

        // Channel 1 CDR lock chatters faster than the stability window.
        apply_reset();
        per = $urandom_range(4, 12);
        seen = 1'b0;
        ready_at[0] = 0;
        for (int i = 1; i <= 120; i++) begin
            if (i % per == 0) bus.rx_cdr_lol_ch_s[1] = ~bus.rx_cdr_lol_ch_s[1];
            tick();
            if (bus.rx_ready[1]) seen = 1'b1;
            if (bus.rx_ready[0] && ready_at[0] == 0) ready_at[0] = i;
        end
        check("t2_ch0_ready_at", ready_at[0], READY_TICK);
        check("t2_ch1_never_ready", 32'(seen), 32'(0));
        bus.rx_cdr_lol_ch_s[1] = 1'b0;
        wait_ready('1, 200, "t2_recover");

        // Persistent loss of lock on channel 2, starting from NORMAL.
        bus.rx_cdr_lol_ch_s[2] = 1'b1;
        rises = 0;
        prev  = bus.rx_serdes_rst_ch_c[2];
        n     = 0;
        while (!bus.rx_fault[2] && n < 400) begin
            tick();
            n++;
            if (bus.rx_serdes_rst_ch_c[2] && !prev) rises++;
            prev = bus.rx_serdes_rst_ch_c[2];
        end
        check("t3_fault", 32'(bus.rx_fault[2]), 32'(1));
        check("t3_pulses", rises, MAX_RETRY);
        check("t3_pcs_in_fault", 32'(bus.rx_pcs_rst_ch_c[2]), 32'(1));
        repeat (20) tick();
        check("t3_sticky", 32'(bus.rx_fault[2]), 32'(1));
        bus.rx_cdr_lol_ch_s[2] = 1'b0;
        bus.fault_clr[2] = 1'b1;
        tick();
        bus.fault_clr[2] = 1'b0;
        n = 0;
        while (!bus.rx_serdes_rst_ch_c[2] && n < 8) begin
            tick();
            n++;
        end
        check("t3_restart", 32'(bus.rx_serdes_rst_ch_c[2]), 32'(1));
        check("t3_fault_cleared", 32'(bus.rx_fault[2]), 32'(0));
        wait_ready('1, 200, "t3_recover");

        // One-cycle LOS glitch on channel 0 while in NORMAL.
        bus.rx_los_low_ch_s[0] = 1'b1;
        tick();
        bus.rx_los_low_ch_s[0] = 1'b0;
        lat = 1;
        while ((bus.rx_ready[0] || !bus.rx_pcs_rst_ch_c[0]) && lat < 8) begin
            tick();
            lat++;
        end
        check("t5_drop_latency", lat, 4);
        wait_ready('1, 200, "t5_recover");

        // Power-down of channel 3 during its serdes reset pulse.
        bus.rx_los_low_ch_s[3] = 1'b1;
        tick();
        bus.rx_los_low_ch_s[3] = 1'b0;
        n = 0;
        while (!bus.rx_serdes_rst_ch_c[3] && n < 20) begin
            tick();
            n++;
        end
        check("t4_serdes_up", 32'(bus.rx_serdes_rst_ch_c[3]), 32'(1));
        bus.power_down[3] = 1'b1;
        tick();
        tick();
        check("t4_serdes_hold", 32'(bus.rx_serdes_rst_ch_c[3]), 32'(1));
        tick();
        check("t4_serdes_drop", 32'(bus.rx_serdes_rst_ch_c[3]), 32'(0));
        repeat (10) tick();
        check("t4_parked_pcs", 32'(bus.rx_pcs_rst_ch_c[3]), 32'(1));
        check("t4_parked_serdes", 32'(bus.rx_serdes_rst_ch_c[3]), 32'(0));
        bus.power_down[3] = 1'b0;
        n = 0;
        while (!bus.rx_serdes_rst_ch_c[3] && n < 10) begin
            tick();
            n++;
        end
        check("t4_resequence", 32'(bus.rx_serdes_rst_ch_c[3]), 32'(1));
        wait_ready('1, 200, "t4_recover");

        // Random status churn on all channels.
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 39) == 0) bus.rx_cdr_lol_ch_s[c] = ~bus.rx_cdr_lol_ch_s[c];
                if ($urandom_range(0, 59) == 0) bus.rx_los_low_ch_s[c] = ~bus.rx_los_low_ch_s[c];
                if (bus.power_down[c]) begin
                    if ($urandom_range(0, 7) == 0) bus.power_down[c] = 1'b0;
                end else if ($urandom_range(0, 99) == 0) begin
                    bus.power_down[c] = 1'b1;
                end
                bus.fault_clr[c] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 49) == 0) bus.tx_pll_lol_qd_s = ~bus.tx_pll_lol_qd_s;
            tick();
        end
        bus.tx_pll_lol_qd_s = 1'b0;
        bus.rx_cdr_lol_ch_s = '0;
        bus.rx_los_low_ch_s = '0;
        bus.power_down      = '0;
        bus.fault_clr       = '1;
        tick();
        bus.fault_clr       = '0;
        wait_ready('1, 300, "rand_recover");

        // Asynchronous reset with channel 1 mid-stability-window and the rest in NORMAL.
        bus.rx_los_low_ch_s[1] = 1'b1;
        tick();
        bus.rx_los_low_ch_s[1] = 1'b0;
        repeat (T1_CYCLES + 12) tick();
        check("t6_pre_ready", 32'(bus.rx_ready), 32'(4'b1101));
        #2;
        apply_reset();
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
